// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and defaults for the serial-add arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SA_WIDTH_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/serial_fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : serial_fa_cell
// Description : 1-bit full adder with registered carry for bit-serial addition.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_fa_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry_out
);

    logic r_carry;
    logic w_half;

    assign w_half    = a ^ b;
    assign sum       = w_half ^ r_carry;
    assign carry_out = (a & b) | (r_carry & w_half);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (clr) begin
            r_carry <= 1'b0;
        end else if (en) begin
            r_carry <= carry_out;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_arbiter
// Description : Round-robin arbiter sharing one bit-serial adder between two
//               requesters; returns a WIDTH+1-bit sum tagged with the owner id.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_arbiter
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_a,
    input  logic [WIDTH-1:0] in0_b,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_a,
    input  logic [WIDTH-1:0] in1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_id
);

    localparam int              C_CNT_W = $clog2(WIDTH + 1);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last_grant;
    logic [WIDTH-1:0]     r_a_sr;
    logic [WIDTH-1:0]     r_b_sr;
    logic [WIDTH-1:0]     r_sum_lo;
    logic                 r_sum_msb;
    logic                 r_out_id;
    logic [C_CNT_W-1:0]   r_cnt;

    logic                 w_grant;
    logic                 w_in0_ready;
    logic                 w_in1_ready;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_run;
    logic                 w_last_bit;
    logic                 w_fa_sum;
    logic                 w_fa_cout;

    // Ties go to the channel that did not win last time.
    always_comb begin
        w_grant = 1'b0;
        if (in0_valid && in1_valid) begin
            w_grant = ~r_last_grant;
        end else if (in1_valid) begin
            w_grant = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in0_ready = 1'b0;
        w_in1_ready = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in0_ready = in0_valid & ~w_grant;
                w_in1_ready = in1_valid &  w_grant;
                if (in0_valid || in1_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last_bit) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    assign in0_ready  = rst_n & w_in0_ready;
    assign in1_ready  = rst_n & w_in1_ready;
    assign out_valid  = w_out_valid;
    assign w_accept   = in0_ready | in1_ready;
    assign w_run      = (r_state == RUN);
    assign w_last_bit = (r_cnt == C_LAST);
    assign out_sum    = {r_sum_msb, r_sum_lo};
    assign out_id     = r_out_id;

    serial_fa_cell u_fa (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_accept),
        .en        (w_run),
        .a         (r_a_sr[0]),
        .b         (r_b_sr[0]),
        .sum       (w_fa_sum),
        .carry_out (w_fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_sum_lo     <= '0;
            r_sum_msb    <= 1'b0;
            r_out_id     <= 1'b0;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_a_sr       <= w_grant ? in1_a : in0_a;
            r_b_sr       <= w_grant ? in1_b : in0_b;
            r_sum_lo     <= '0;
            r_sum_msb    <= 1'b0;
            r_out_id     <= w_grant;
            r_cnt        <= '0;
            r_last_grant <= w_grant;
        end else if (w_run) begin
            // Sum bits enter at the MSB so the first bit lands at bit 0 after WIDTH shifts.
            r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_sum_lo <= {w_fa_sum, r_sum_lo[WIDTH-1:1]};
            r_cnt    <= r_cnt + C_CNT_W'(1);
            if (w_last_bit) begin
                r_sum_msb <= w_fa_cout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_arbiter
// Description : Self-checking bench for serial_add_arbiter (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in0_valid, in1_valid;
    logic         in0_ready, in1_ready;
    logic [W-1:0] in0_a, in0_b, in1_a, in1_b;
    logic         out_valid, out_ready;
    logic [W:0]   out_sum;
    logic         out_id;

    int           checks;
    int           errors;
    int           n_acc;
    logic [W+1:0] sb_q[$];

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_a     (in0_a),
        .in0_b     (in0_b),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_a     (in1_a),
        .in1_b     (in1_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected {id, a+b} pushed on accept, popped on result handshake.
    always @(negedge clk) begin
        logic [W:0]   s;
        logic [W+1:0] exp;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (in0_ready && in1_ready) begin
                errors++;
                $display("FAIL both_ready got %b%b want not both", in0_ready, in1_ready);
            end
            if (in0_ready && in0_valid) begin
                s = {1'b0, in0_a} + {1'b0, in0_b};
                sb_q.push_back({1'b0, s});
                n_acc++;
            end
            if (in1_ready && in1_valid) begin
                s = {1'b0, in1_a} + {1'b0, in1_b};
                sb_q.push_back({1'b1, s});
                n_acc++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got id=%0d sum=%h want no result", out_id, out_sum);
                end else begin
                    exp = sb_q.pop_front();
                    if ({out_id, out_sum} !== exp) begin
                        errors++;
                        $display("FAIL sb_result got id=%0d sum=%h want id=%0d sum=%h",
                                 out_id, out_sum, exp[W+1], exp[W:0]);
                    end
                end
            end
        end
    end

    task automatic wait_out(output logic [W:0] s, output logic id, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_timeout got out_valid=0 want 1");
        end
        s  = out_sum;
        id = out_id;
    endtask

    task automatic send(input logic ch, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(posedge clk); #1;
        if (ch) begin in1_valid = 1'b1; in1_a = a; in1_b = b; end
        else    begin in0_valid = 1'b1; in0_a = a; in0_b = b; end
        n = 0;
        @(negedge clk);
        while (!(ch ? in1_ready : in0_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout ch=%0d got ready=0 want 1", ch);
        end
        @(posedge clk); #1;
        if (ch) in1_valid = 1'b0; else in0_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1;
        in0_valid = 1'b1; in1_valid = 1'b1;
        in0_a = 8'h11; in0_b = 8'h22; in1_a = 8'h33; in1_b = 8'h44;
        #22;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        if (out_sum !== '0)     begin errors++; $display("FAIL rst_out_sum got %h want 000", out_sum); end
        if (out_id !== 1'b0)    begin errors++; $display("FAIL rst_out_id got %b want 0", out_id); end
        if (in0_ready !== 1'b0) begin errors++; $display("FAIL rst_in0_ready got %b want 0", in0_ready); end
        if (in1_ready !== 1'b0) begin errors++; $display("FAIL rst_in1_ready got %b want 0", in1_ready); end
        @(posedge clk); #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W:0] s; logic id; int n;
        @(posedge clk); #1;
        in0_valid = 1'b1; in0_a = 8'h5A; in0_b = 8'h3C;
        @(negedge clk);
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready got %b%b want 10", in0_ready, in1_ready);
        end
        @(posedge clk); #1;
        in0_valid = 1'b0;
        wait_out(s, id, n);
        checks += 3;
        if (n - 1 !== 8)     begin errors++; $display("FAIL basic_latency got %0d want 8", n - 1); end
        if (s !== 9'h096)    begin errors++; $display("FAIL basic_sum got %h want 096", s); end
        if (id !== 1'b0)     begin errors++; $display("FAIL basic_id got %b want 0", id); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [W:0] s; logic id; int n;
        send(1'b1, 8'hFF, 8'h01);
        wait_out(s, id, n);
        checks += 2;
        if (s !== 9'h100) begin errors++; $display("FAIL ovf1_sum got %h want 100", s); end
        if (id !== 1'b1)  begin errors++; $display("FAIL ovf1_id got %b want 1", id); end
        send(1'b0, 8'hFF, 8'hFF);
        wait_out(s, id, n);
        checks += 2;
        if (s !== 9'h1FE) begin errors++; $display("FAIL ovf2_sum got %h want 1fe", s); end
        if (id !== 1'b0)  begin errors++; $display("FAIL ovf2_id got %b want 0", id); end
        send(1'b0, 8'h00, 8'h00);
        wait_out(s, id, n);
        checks++;
        if (s !== 9'h000) begin errors++; $display("FAIL zero_sum got %h want 000", s); end
    endtask

    task automatic test_contention();
        logic [W:0] sums[4];
        logic       ids[4];
        logic [W:0] exp_s;
        int k, c0, c1, cyc;
        apply_reset();
        in0_a = 8'h12; in0_b = 8'h34; in1_a = 8'hF0; in1_b = 8'h20;
        in0_valid = 1'b1; in1_valid = 1'b1;
        k = 0; c0 = 0; c1 = 0; cyc = 0;
        while (k < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (in0_ready) c0++;
            if (in1_ready) c1++;
            if (out_valid && out_ready) begin
                sums[k] = out_sum;
                ids[k]  = out_id;
                k++;
            end
        end
        @(posedge clk); #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL cont_count got %0d want 4", k);
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_s = (i % 2 == 1) ? 9'h110 : 9'h046;
                checks++;
                if (ids[i] !== 1'(i % 2) || sums[i] !== exp_s) begin
                    errors++;
                    $display("FAIL cont_order[%0d] got id=%0d sum=%h want id=%0d sum=%h",
                             i, ids[i], sums[i], i % 2, exp_s);
                end
            end
        end
        checks++;
        if (c0 != 2 || c1 != 2) begin
            errors++;
            $display("FAIL cont_ready_pulses got %0d/%0d want 2/2", c0, c1);
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] s; logic id; int n;
        out_ready = 1'b0;
        send(1'b0, 8'h81, 8'h7F);
        in1_valid = 1'b1; in1_a = 8'h11; in1_b = 8'h22;
        wait_out(s, id, n);
        checks++;
        if (s !== 9'h100 || id !== 1'b0) begin
            errors++;
            $display("FAIL bp_first got id=%0d sum=%h want id=0 sum=100", id, s);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 9'h100 || out_id !== 1'b0 ||
                in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b sum=%h id=%b rdy=%b%b want v=1 sum=100 id=0 rdy=00",
                         i, out_valid, out_sum, out_id, in0_ready, in1_ready);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in1_ready !== 1'b1) begin errors++; $display("FAIL bp_release got in1_ready=%b want 1", in1_ready); end
        @(posedge clk); #1;
        in1_valid = 1'b0;
        wait_out(s, id, n);
        checks++;
        if (s !== 9'h033 || id !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got id=%0d sum=%h want id=1 sum=033", id, s);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W:0] s; logic id; int n;
        send(1'b0, 8'h0F, 8'h01);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        in0_a = 8'h33; in0_b = 8'h44; in1_a = 8'h55; in1_b = 8'h66;
        in0_valid = 1'b1; in1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_outputs got v=%b rdy=%b%b want 0 00", out_valid, in0_ready, in1_ready);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_grant got %b%b want 10", in0_ready, in1_ready);
        end
        @(posedge clk); #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        wait_out(s, id, n);
        checks++;
        if (s !== 9'h077 || id !== 1'b0 || n - 1 !== 8) begin
            errors++;
            $display("FAIL mid_rst_next got id=%0d sum=%h lat=%0d want id=0 sum=077 lat=8", id, s, n - 1);
        end
    endtask

    task automatic test_random();
        int acc0, cyc;
        acc0 = n_acc;
        cyc  = 0;
        while (n_acc - acc0 < 1000 && cyc < 40000) begin
            @(posedge clk); #1;
            in0_valid = 1'($urandom_range(0, 1));
            in1_valid = 1'($urandom_range(0, 1));
            in0_a = W'($urandom); in0_b = W'($urandom);
            in1_a = W'($urandom); in1_b = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        checks++;
        if (n_acc - acc0 < 1000) begin
            errors++;
            $display("FAIL rand_accepts got %0d want 1000", n_acc - acc0);
        end
        @(posedge clk); #1;
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got %0d pending want 0", sb_q.size());
        end
    endtask

    initial begin
        checks = 0; errors = 0; n_acc = 0;
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        in0_a = '0; in0_b = '0; in1_a = '0; in1_b = '0;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_contention();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_add_arbiter.md
Name: serial_add_arbiter

Overview:
- Shares one 1-bit serial full-adder datapath between two requesters. Each requester supplies a pair of WIDTH-bit operands.
- The block arbitrates round-robin, shifts the operands LSB-first through the adder over WIDTH cycles and collects the sum bits. It returns a WIDTH+1-bit result tagged with the requester id.
- Sits between parallel-operand producers and a single result consumer. Both sides use valid/ready handshakes.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in0_valid  input  1  requester 0 holds operands.
- in0_ready  output  1  requester 0 operands accepted this cycle.
- in0_a  input  WIDTH  requester 0 operand A.
- in0_b  input  WIDTH  requester 0 operand B.
- in1_valid  input  1  requester 1 holds operands.
- in1_ready  output  1  requester 1 operands accepted this cycle.
- in1_a  input  WIDTH  requester 1 operand A.
- in1_b  input  WIDTH  requester 1 operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_sum  output  WIDTH+1  {carry_out, sum[WIDTH-1:0]} = a + b.
- out_id  output  1  requester that owns out_sum.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - Reset is asynchronous and active-low (rst_n). Asserting rst_n=0 forces all state immediately; release is synchronous to clk.
- Reset values:
  - FSM=IDLE, out_valid=0, out_sum=0, out_id=0.
  - in0_ready=0, in1_ready=0, shift registers=0, carry=0, bit counter=0.
  - last_grant=1, so channel 0 wins the first tie.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - grant = the only valid channel. If both are valid, grant the channel != last_grant.
  - inX_ready = (state==IDLE) & grant==X, combinational from inX_valid. It is never high for both channels at once.
  - Accept edge T0 (valid&ready):
    - Load a_sr and b_sr with the granted operands.
    - Clear carry and bit counter.
    - Set out_id=grant and last_grant=grant.
    - Go to RUN.
  - Operands need not stay stable after T0.
- RUN:
  - Each edge computes s = a_sr[0]^b_sr[0]^carry.
  - carry <= (a_sr[0]&b_sr[0]) | (carry&(a_sr[0]^b_sr[0])).
  - s shifts into the result register MSB; a_sr and b_sr shift right.
  - The counter increments each edge. On the WIDTH-th RUN edge (T0+WIDTH), the final carry is stored as out_sum[WIDTH] and the FSM goes to DONE.
- DONE:
  - out_valid=1 from edge T0+WIDTH.
  - out_sum and out_id stay stable until out_ready=1 is sampled on an edge; then out_valid=0 and the FSM goes to IDLE.
  - in0_ready and in1_ready stay 0 throughout RUN and DONE.
- Timing:
  - Latency from accept edge to out_valid high: WIDTH cycles.
  - Minimum issue interval: WIDTH+2 cycles with out_ready tied high.
- Arithmetic:
  - Unsigned; out_sum = a + b exactly.
  - Overflow appears only in out_sum[WIDTH]; there is no wrap.
- Boundary conditions:
  - a=b=0 gives 0.
  - All-ones + all-ones gives 2^(WIDTH+1)-2.
  - A requester that drops valid before it is granted is not serviced.
  - Arbitration is starvation-free: under continuous contention the grants alternate.
- Reset mid-operation (rst_n low in RUN or DONE):
  - The operation is aborted and the result is discarded; no out_valid pulse.
  - After release the FSM is in IDLE and last_grant=1.
- Datapath:
  - The adder datapath uses only ^, &, | and ~.
  - No + operator in the adder datapath. The counter may use +.

Decomposition:
- Package serial_add_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - Default width constant SA_WIDTH_DEFAULT=8.
- Sub-module serial_fa_cell:
  - 1-bit full adder plus carry flop.
  - Inputs: clk, rst_n, clr, en, a, b.
  - Outputs: sum (combinational), carry_out (next-carry value).
  - Carry clears on clr (accept) and updates on en (RUN).
- The top level holds the arbiter, FSM, shift registers, counter and result register.

Test Plan:
- WIDTH=8; in0 sends a=0x5A, b=0x3C; out_ready=1 -> in0_ready high in the accept cycle; out_valid high 8 cycles after accept with out_sum=0x096, out_id=0; one-cycle pulse.
- Overflow: in1 sends 0xFF+0x01 -> out_sum=0x100, out_id=1. 0xFF+0xFF -> out_sum=0x1FE.
- Contention: both valid from reset and held, with distinct operands -> results come out in order id 0, 1, 0, 1 with the correct sums. Each in_ready pulses exactly once per grant, never both in the same cycle.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_sum and out_id stay stable and in0_ready/in1_ready stay 0. After out_ready=1, the FSM returns to IDLE and accepts a pending request on the next cycle.
- Reset mid-RUN: assert rst_n=0 at accept+3 for 2 cycles -> immediately out_valid=0 and in_ready=0; no result appears for the aborted op. The next request (both channels valid) goes to channel 0 and completes correctly.
- Random: 1000 transactions with random valid and out_ready patterns -> every accepted op yields out_sum == a+b with the correct id, in acceptance order.
